// File: rtl/pdm_fader.sv
// pdm_fader: brightness ramp engine feeding a PDM LED driver.
// Accepts target/step commands on a valid/ready handshake and walks `level`
// toward the target by `step` on every prescaler tick, landing exactly on the
// target without overshoot.
// Optional feature macro: PDM_FADER_RETARGET_EN (allows new commands while a
// ramp is running; the new command restarts the ramp from the current level).
module pdm_fader #(
  parameter int N          = 16,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [N-1:0]          cmd_target,
  input  logic [N-1:0]          cmd_step,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [N-1:0]          level,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  localparam logic [N-1:0]          STEP_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] CNT_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  state_t                  state_q,  state_d;
  logic [N-1:0]            level_q,  level_d;
  logic [N-1:0]            target_q, target_d;
  logic [N-1:0]            step_q,   step_d;
  logic [PRESCALE_W-1:0]   cnt_q,    cnt_d;
  logic                    done_q,   done_d;

  logic                    accept_s;
  logic                    tick_s;
  logic [N-1:0]            step_eff_s;
  logic [N:0]              up_gap_s;
  logic [N:0]              down_gap_s;

`ifdef PDM_FADER_RETARGET_EN
  // Commands are taken in any state once reset is released.
  assign cmd_ready = rst_n;
`else
  // Commands are taken only while idle and out of reset.
  assign cmd_ready = rst_n & (state_q == ST_IDLE);
`endif

  assign accept_s   = cmd_valid & cmd_ready;
  assign tick_s     = (state_q != ST_IDLE) && (cnt_q == prescale);
  assign step_eff_s = (cmd_step == {N{1'b0}}) ? STEP_ONE : cmd_step;

  // Distances to the target in N+1 bits so the compare can never wrap.
  assign up_gap_s   = {1'b0, target_q} - {1'b0, level_q};
  assign down_gap_s = {1'b0, level_q} - {1'b0, target_q};

  assign level = level_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;

  // Next-state logic: command accept has priority over a ramp tick.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    target_d = target_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;

    if (state_q == ST_IDLE) begin
      cnt_d = {PRESCALE_W{1'b0}};
    end else if (tick_s) begin
      cnt_d = {PRESCALE_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    if (accept_s) begin
      target_d = cmd_target;
      step_d   = step_eff_s;
      cnt_d    = {PRESCALE_W{1'b0}};
      if (cmd_target > level_q) begin
        state_d = ST_UP;
      end else if (cmd_target < level_q) begin
        state_d = ST_DOWN;
      end else begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else if (tick_s) begin
      case (state_q)
        ST_UP: begin
          if (up_gap_s <= {1'b0, step_q}) begin
            level_d = target_q;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            level_d = level_q + step_q;
          end
        end
        ST_DOWN: begin
          if (down_gap_s <= {1'b0, step_q}) begin
            level_d = target_q;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            level_d = level_q - step_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      level_d = level_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      level_q  <= {N{1'b0}};
      target_q <= {N{1'b0}};
      step_q   <= STEP_ONE;
      cnt_q    <= {PRESCALE_W{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: doc/pdm_fader.md
Name: pdm_fader

Overview:
- Brightness ramp engine directly upstream of the PDM LED driver; its `level` output connects straight to the PDM `level` input.
- Accepts target/step commands over a valid/ready handshake.
- Moves `level` toward the target by `step` on each prescaler tick, saturating exactly at the target.
- Gives smooth fade-in/fade-out instead of abrupt brightness jumps.

Parameters:
- N, 16, level resolution in bits; must match the downstream PDM N.
- PRESCALE_W, 16, width of the tick prescaler.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_target  in  N  desired final level.
- cmd_step  in  N  increment per tick; 0 is treated as 1.
- prescale  in  PRESCALE_W  tick period minus 1; sampled live every cycle.
- level  out  N  current brightness, registered, to PDM.
- busy  out  1  ramp in progress (state UP or DOWN).
- done  out  1  one-cycle pulse when level reaches target.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, level=0, target=0, step=1, prescaler count=0, done=0. A command presented during a reset cycle is never accepted.
- States and cmd_ready:
  - States are IDLE, UP, DOWN.
  - cmd_ready = (state==IDLE) when rst_n high; 0 while rst_n low.
  - busy = (state!=IDLE).
- Accept: cmd_valid & cmd_ready at an edge.
  - Latch target and step (0→1).
  - Clear the prescaler count.
  - Go to UP if target>level, DOWN if target<level.
  - If target==level, stay IDLE and assert done for the next cycle.
- Prescaler:
  - In UP/DOWN, the count increments each cycle.
  - tick = (count==prescale); on tick, count returns to 0.
  - prescale=0 gives a tick every cycle.
  - If prescale changes below the current count, the count wraps through 2^PRESCALE_W naturally. This is acceptable; no special handling.
  - The count is held at 0 in IDLE.
- Ramp step on tick, arithmetic in N+1 bits:
  - UP: if target−level <= step, then level←target, state←IDLE, done←1; else level←level+step.
  - DOWN: if level−target <= step, then level←target, state←IDLE, done←1; else level←level−step.
- No overshoot and no wrap-around: level stays in [0, 2^N−1] and is monotonic within a ramp.
- Latency:
  - The first level change is visible prescale+1 cycles after the accept edge.
  - done is high in the same cycle level first equals target.
  - done is otherwise 0.
  - The next command can be accepted in the cycle done is high.
- Reset mid-ramp: level snaps to 0 and the FSM goes to IDLE; no done pulse.
- level changes only on tick edges or reset.

Optional Feature:
- Macro: PDM_FADER_RETARGET_EN.
- Defined:
  - cmd_ready = rst_n in all states.
  - A command accepted during UP/DOWN replaces target/step and clears the prescaler.
  - Direction is re-evaluated against the current level. If the new target equals level, go to IDLE with a done pulse.
  - An accept on the same edge as a tick takes priority: that tick's step is discarded.
- Undefined: cmd_ready is low in UP/DOWN; commands wait until IDLE.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with cmd_valid=1 → level=0, busy=0, done=0, no accept; after release, cmd_ready=1.
- Ramp up: prescale=0, target=0x0010, step=4 from 0 → level 0x0004, 0x0008, 0x000C, 0x0010 on consecutive cycles after accept; done high only with 0x0010; busy high for exactly 4 cycles.
- Saturation: from 0x0010, target=0x0012, step=0x0100 → one tick to 0x0012, no overshoot; then target=0x0000, step=0xFFFF → 0x0000 in one tick; then target=0xFFFF, step=0 → 0x0001, 0x0002, … with step treated as 1; abort that ramp via reset → level 0.
- Prescaler: prescale=3, target=0x0003, step=1 from 0 → level changes every 4 cycles (at cycles 4, 8, 12 after accept); cmd_ready=0 throughout (macro off).
- Equal target: level=0x0040, command target=0x0040 → no busy, done pulse next cycle, level unchanged.
- Retarget (macro on): ramping up 0→0x0100 step 0x10, at level 0x0050 issue target=0x0020 step 0x10 → state DOWN, levels 0x0040, 0x0030, 0x0020, done once at 0x0020 only.
